// File: rtl/sram_timed_ctrl.sv
// Timed asynchronous-SRAM controller: one access at a time with programmable
// read/write lengths, write turnaround, and an in-order response FIFO.
module sram_timed_ctrl #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter int RD_CYCLES  = 2,
    parameter int WR_CYCLES  = 3,
    parameter int TURNAROUND = 1,
    parameter int RESP_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic                    we,
    input  logic                    req_valid,
    output logic                    req_ready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    resp_we,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    inout  wire  [DATA_WIDTH-1:0]   sram_data,
    output logic                    sram_ce_n,
    output logic                    sram_oe_n,
    output logic                    sram_we_n,
    output logic [DATA_WIDTH/8-1:0] sram_be_n
);
    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int MC1    = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int MAX_C  = (MC1 > TURNAROUND) ? MC1 : TURNAROUND;
    localparam int CNT_W  = $clog2(MAX_C + 1);
    localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int FCNT_W = $clog2(RESP_DEPTH + 1);
    localparam int OCC_W  = $clog2(RESP_DEPTH + 2);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_TURN} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [BE_W-1:0]         wbe_q;
    logic                    ce_n_q, oe_n_q, we_n_q;
    logic                    ce_n_d, oe_n_d, we_n_d;
    logic [BE_W-1:0]         be_n_q, be_n_d, lane_en_q, lane_en_d;
    logic [DATA_WIDTH-1:0]   mem_data_q [RESP_DEPTH];
    logic                    mem_we_q   [RESP_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [FCNT_W-1:0]       count_q;

    logic                    last_rd_s, last_wr_s, busy_s, enq_s, push_s, pop_s;
    logic [OCC_W-1:0]        occ_s;
    logic [BE_W-1:0]         wbe_nxt_s;
    logic [DATA_WIDTH-1:0]   push_data_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(RESP_DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign last_rd_s   = (state_q == S_READ)  && (cnt_q == CNT_W'(RD_CYCLES - 1));
    assign last_wr_s   = (state_q == S_WRITE) && (cnt_q == CNT_W'(WR_CYCLES - 1));
    assign busy_s      = (state_q == S_READ) || (state_q == S_WRITE);
    // The in-flight access already owns a FIFO slot, so it counts toward occupancy.
    assign occ_s       = OCC_W'(count_q) + OCC_W'(busy_s);
    assign req_ready   = (occ_s < OCC_W'(RESP_DEPTH)) && ((state_q == S_IDLE) || last_rd_s);
    assign enq_s       = req_valid && req_ready;
    assign push_s      = last_rd_s || last_wr_s;
    assign push_data_s = last_rd_s ? sram_data : {DATA_WIDTH{1'b0}};
    assign resp_valid  = (count_q != {FCNT_W{1'b0}});
    assign pop_s       = resp_valid && resp_ready;
    assign rdata       = mem_data_q[rd_ptr_q];
    assign resp_we     = mem_we_q[rd_ptr_q];
    assign wbe_nxt_s   = enq_s ? wbe : wbe_q;

    // Next-state and counter sequencing of the access FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (enq_s) begin
                    state_d = we ? S_WRITE : S_READ;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (last_rd_s) begin
                    state_d = enq_s ? (we ? S_WRITE : S_READ) : S_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE: begin
                if (last_wr_s) begin
                    state_d = (TURNAROUND > 0) ? S_TURN : S_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_TURN: begin
                if (cnt_q >= CNT_W'(TURNAROUND - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Strobes are decoded from the next state so the pins come straight from flops.
    always_comb begin
        ce_n_d    = !((state_d == S_READ) || (state_d == S_WRITE));
        oe_n_d    = (state_d != S_READ);
        we_n_d    = !((state_d == S_WRITE) && (cnt_d != CNT_W'(WR_CYCLES - 1)));
        be_n_d    = {BE_W{1'b1}};
        lane_en_d = {BE_W{1'b0}};
        if (state_d == S_WRITE) begin
            be_n_d    = ~wbe_nxt_s;
            lane_en_d = wbe_nxt_s;
        end else if (state_d == S_READ) begin
            be_n_d    = {BE_W{1'b0}};
        end else begin
            be_n_d    = {BE_W{1'b1}};
        end
    end

    // FSM state, request capture and SRAM pin registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            addr_q    <= {ADDR_WIDTH{1'b0}};
            wdata_q   <= {DATA_WIDTH{1'b0}};
            wbe_q     <= {BE_W{1'b0}};
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            be_n_q    <= {BE_W{1'b1}};
            lane_en_q <= {BE_W{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            be_n_q    <= be_n_d;
            lane_en_q <= lane_en_d;
            if (enq_s) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                wbe_q   <= wbe;
            end
        end
    end

    // Response FIFO; a completing access is always guaranteed a free slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RESP_DEPTH; i++) begin
                mem_data_q[i] <= {DATA_WIDTH{1'b0}};
                mem_we_q[i]   <= 1'b0;
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {FCNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_data_q[wr_ptr_q] <= push_data_s;
                mem_we_q[wr_ptr_q]   <= last_wr_s;
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end
            if (pop_s) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + FCNT_W'(1);
                2'b01:   count_q <= count_q - FCNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign sram_addr = addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign sram_be_n = be_n_q;

    for (genvar g = 0; g < BE_W; g++) begin : g_lane
        assign sram_data[g*8 +: 8] = lane_en_q[g] ? wdata_q[g*8 +: 8] : 8'hzz;
    end
endmodule

// File: doc/sram_timed_ctrl.md
SRAM_TIMED_CTRL -- requirements
Module: sram_timed_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20, for the SRAM word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, for the data width; it must be a multiple of 8.
REQ-003 SHALL have parameter RD_CYCLES, default 2, for read access length in clocks; it must be at least 1.
REQ-004 SHALL have parameter WR_CYCLES, default 3, for write access length in clocks; it must be at least 2.
REQ-005 SHALL have parameter TURNAROUND, default 1, for idle bus cycles after each write; it must be at least 0.
REQ-006 SHALL have parameter RESP_DEPTH, default 2, for response FIFO entries; it must be at least 1.
REQ-007 SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all logic on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- addr, in, ADDR_WIDTH, request address.
- wdata, in, DATA_WIDTH, write data.
- wbe, in, DATA_WIDTH/8, write byte enables.
- we, in, 1, request is a write (1) or a read (0).
- req_valid / req_ready, in / out, 1 each, request handshake.
- rdata, out, DATA_WIDTH, response data.
- resp_we, out, 1, response belongs to a write.
- resp_valid / resp_ready, out / in, 1 each, response handshake.
- sram_addr, out, ADDR_WIDTH, SRAM address.
- sram_data, inout, DATA_WIDTH, SRAM data bus.
- sram_ce_n, sram_oe_n, sram_we_n, out, 1 each, active-low strobes.
- sram_be_n, out, DATA_WIDTH/8, active-low byte enables.

Function
REQ-008 SHALL implement states IDLE, READ, WRITE, TURN with a cycle counter.
REQ-009 SHALL define occupancy as FIFO count plus 1 when in READ or WRITE; a pop in the same cycle does not reduce occupancy.
REQ-010 SHALL assert req_ready only when occupancy < RESP_DEPTH, and the FSM is either in IDLE or in the final cycle of a READ.
REQ-011 SHALL, on enqueue (req_valid && req_ready), register addr, wdata, wbe and we, and enter READ or WRITE with the counter at 0.
REQ-012 SHALL, in READ for RD_CYCLES cycles, drive ce_n=0, oe_n=0, we_n=1, be_n=0 on all lanes, and leave sram_data undriven.
REQ-013 SHALL, at the rising edge ending the last READ cycle, sample sram_data and push {data, we=0} into the FIFO.
REQ-014 SHALL, in WRITE for WR_CYCLES cycles, drive ce_n=0, oe_n=1, be_n=~wbe, and drive only the enabled byte lanes of sram_data (others Z).
REQ-015 SHALL hold we_n=0 during WRITE cycles 0..WR_CYCLES-2 and we_n=1 in the last cycle, with data and address held.
REQ-016 SHALL, at the end of the last WRITE cycle, push {rdata=0, we=1} into the FIFO.
REQ-017 SHALL, after the last WRITE cycle, enter TURN for TURNAROUND cycles with all strobes inactive and the bus undriven, then go to IDLE; if TURNAROUND=0 it goes directly to IDLE.
REQ-018 SHALL, when a request is enqueued in the last READ cycle, move directly into the new access, so back-to-back read throughput is one per RD_CYCLES clocks.
REQ-019 SHALL, when no enqueue occurs in the last READ cycle, return to IDLE.
REQ-020 SHALL, in IDLE and TURN, hold ce_n, oe_n and we_n at 1, be_n all 1, and sram_data at Z; sram_addr holds its last value.
REQ-021 SHALL present the FIFO head on rdata/resp_we with resp_valid = FIFO not empty, and pop on resp_valid && resp_ready.
REQ-022 SHALL keep the count unchanged on a simultaneous push and pop; responses are delivered strictly in request order.
REQ-023 SHALL give read latency from enqueue edge to resp_valid high of RD_CYCLES clocks when the FIFO is empty.
REQ-024 SHALL never drive sram_data while oe_n=0, and never assert oe_n=0 and we_n=0 simultaneously.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force: state IDLE, counter 0, FIFO empty, resp_valid=0, strobes=1, be_n all 1, sram_data Z, rdata=0, resp_we=0.
REQ-026 SHALL, on reset asserted mid-access, abort the access with no FIFO push.
REQ-027 SHALL, in the first cycle after rst_n rises, assert req_ready=1.

Verification
REQ-028 Single read (defaults): read addr 0x00010, SRAM model returns 0xDEADBEEF -> oe_n low 2 cycles; resp_valid 2 cycles after enqueue with rdata=0xDEADBEEF, resp_we=0.
REQ-029 Partial write: wbe=0b0101, wdata=0x11223344 -> we_n low 2 cycles then high 1 cycle, then 1 TURN cycle; only lanes 0 and 2 driven; response rdata=0, resp_we=1.
REQ-030 Back-to-back: 4 reads with resp_ready=1 -> accepts spaced exactly 2 clocks apart; responses in order.
REQ-031 Backpressure: resp_ready=0, issue 3 reads -> two complete, req_ready stays low; one pop -> third accepted next cycle.
REQ-032 Reset mid-write: rst_n low in WRITE cycle 1 -> we_n and ce_n go to 1 immediately; after release FIFO is empty and req_ready=1.
REQ-033 Write-then-read: WR then RD -> bus undriven for TURNAROUND cycles between we_n rising and oe_n falling; read data correct.
